// File: rtl/mux_arb_pkg.sv
// Shared state encoding and sizing constants for the two-requester arbiter.
package mux_arb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StG0   = 2'b01,
      StG1   = 2'b10
   } arb_state_e;

   localparam int unsigned MaxHoldDefault = 4;
   // Wide enough for MAX_HOLD-1 across the legal range 2..15.
   localparam int unsigned HoldCntW = 4;

endpackage

// File: rtl/arb_hold_cnt.sv
// Saturating hold counter: counts cycles a grant is retained, flags when the limit is reached.
module arb_hold_cnt
   import mux_arb_pkg::*;
#(
   parameter int unsigned MaxHold = MaxHoldDefault
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic sat_o
);

   localparam logic [HoldCntW-1:0] SatVal = HoldCntW'(MaxHold - 1);

   logic [HoldCntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != SatVal)) begin
         cnt_d = cnt_q + HoldCntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_o = (cnt_q == SatVal);

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter with bounded hold time driving a shared output mux.
module mux2_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned DW       = 1,
   parameter int unsigned MAX_HOLD = MaxHoldDefault
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic [DW-1:0] in0,
   input  logic [DW-1:0] in1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          sel,
   output logic [DW-1:0] out,
   output logic          valid
);

   arb_state_e state_q, state_d;
   logic       ptr_q, ptr_d;
   logic       gnt0_q, gnt1_q;
   logic       hold_sat, hold_clr, hold_en;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (req0 && req1) begin
               state_d = ptr_q ? StG1 : StG0;
            end else if (req0) begin
               state_d = StG0;
            end else if (req1) begin
               state_d = StG1;
            end
         end
         StG0: begin
            if (!req0) begin
               state_d = req1 ? StG1 : StIdle;
            end else if (req1 && hold_sat) begin
               state_d = StG1;
            end
         end
         StG1: begin
            if (!req1) begin
               state_d = req0 ? StG0 : StIdle;
            end else if (req0 && hold_sat) begin
               state_d = StG0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Pointer moves to the other side on each grant entry; it holds through IDLE.
   always_comb begin
      ptr_d = ptr_q;
      if (state_d != state_q) begin
         if (state_d == StG0) begin
            ptr_d = 1'b1;
         end else if (state_d == StG1) begin
            ptr_d = 1'b0;
         end
      end
   end

   assign hold_clr = (state_d != state_q);
   assign hold_en  = (state_d == state_q) && (state_q != StIdle);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt0_q  <= (state_d == StG0);
         gnt1_q  <= (state_d == StG1);
      end
   end

   arb_hold_cnt #(
      .MaxHold (MAX_HOLD)
   ) u_hold_cnt (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (hold_clr),
      .en_i  (hold_en),
      .sat_o (hold_sat)
   );

   assign gnt0  = gnt0_q;
   assign gnt1  = gnt1_q;
   assign sel   = gnt1_q;
   assign valid = gnt0_q | gnt1_q;
   assign out   = valid ? (sel ? in1 : in0) : '0;

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 SHALL have parameter DW, default 1: width of each data input and of out.
REQ-002 SHALL have parameter MAX_HOLD, default 4, legal range 2..15: maximum consecutive grant cycles while the other side is requesting.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req0, input, 1 bit: requester 0 wants the shared output.
REQ-006 SHALL have port req1, input, 1 bit: requester 1 wants the shared output.
REQ-007 SHALL have port in0, input, DW bits: requester 0 data.
REQ-008 SHALL have port in1, input, DW bits: requester 1 data.
REQ-009 SHALL have port gnt0, output, 1 bit: requester 0 owns the output (registered).
REQ-010 SHALL have port gnt1, output, 1 bit: requester 1 owns the output (registered).
REQ-011 SHALL have port sel, output, 1 bit: mux select; 1 only while gnt1 is high.
REQ-012 SHALL have port out, output, DW bits: combinational value, sel ? in1 : in0 when valid is high, 0 otherwise.
REQ-013 SHALL have port valid, output, 1 bit: gnt0 | gnt1.

Function
REQ-014 SHALL implement a 3-state FSM with states IDLE, G0 and G1; gnt0 = (state==G0) and gnt1 = (state==G1); never both high.
REQ-015 SHALL give a 1-cycle latency from req sampled high in IDLE to the matching gnt high.
REQ-016 IDLE: with only req0 -> G0; with only req1 -> G1; with both -> the side indicated by priority pointer ptr; with neither -> stay in IDLE.
REQ-017 G0: !req0 & req1 -> G1; !req0 & !req1 -> IDLE; req0 & req1 & hold_cnt==MAX_HOLD-1 -> G1; otherwise stay in G0. G1 is symmetric.
REQ-018 hold_cnt SHALL clear to 0 on every entry into G0 or G1, increment each cycle the grant is retained, and saturate at MAX_HOLD-1.
REQ-019 A requester that holds a grant with no competition SHALL keep it indefinitely; when the other side then requests with hold_cnt saturated, the grant SHALL switch at the next edge.
REQ-020 ptr SHALL update on every grant entry to point at the side not just granted (round-robin); ptr SHALL be unchanged in IDLE.
REQ-021 The direct G0<->G1 hand-off SHALL take exactly one edge, with no IDLE cycle between grants.
REQ-022 Req inputs SHALL be sampled only at rising clk edges; glitches between edges have no effect.

Reset
REQ-023 rst high SHALL immediately (asynchronously) force state=IDLE, gnt0=0, gnt1=0, sel=0, valid=0, out=0, hold_cnt=0 and ptr=0 (requester 0 wins the first tie).
REQ-024 Reset asserted mid-grant SHALL drop the grant in the same cycle; after release, arbitration SHALL restart from IDLE with ptr=0.

Structure
REQ-025 SHALL take the state encoding constants (IDLE=2'b00, G0=2'b01, G1=2'b10) and the default MAX_HOLD from a shared package, mux_arb_pkg.
REQ-026 SHALL place the saturating hold counter in one sub-module, arb_hold_cnt, with clear, enable and saturation-flag ports.
REQ-027 SHALL keep the output mux combinational inside mux2_arbiter, driven only by the registered sel and valid.

Verification
REQ-028 Reset then req0=1 and req1=0 for 3 cycles -> gnt0=1 from cycle 2 onward, sel=0, out=in0, gnt1=0 throughout.
REQ-029 From IDLE with ptr=0, req0=req1=1 held continuously and MAX_HOLD=4 -> gnt0 for 4 cycles, then gnt1 for 4 cycles, alternating; no IDLE gaps.
REQ-030 gnt0 active with req1=1, req0 dropped -> gnt1=1 and sel=1 at the next edge; out follows in1 (in0=8'hA5, in1=8'h3C, DW=8 -> out=8'h3C).
REQ-031 req0 alone for 10 cycles, then req1 raised -> gnt1 one edge later (counter saturated); ptr then favours requester 0.
REQ-032 rst pulsed mid-grant (gnt1=1) between edges -> gnt1, sel, valid and out go to 0 immediately; after release, a simultaneous request grants requester 0.
REQ-033 Both requests dropped while granted -> IDLE at the next edge, valid=0, out=0.
